// File: rtl/keypad_scan_if.sv
// Keypad scanner bus: matrix row/column lines plus the accepted-key output.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // key_valid is a one-cycle event with no ready: the consumer takes key_code in
  // the cycle key_valid is high, and key_code then holds until the next accepted key.
  modport master (input row_in, output col_out, key_code, key_valid, key_down);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with synchronizer, debounce and key-code output.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp,
  output logic [1:0]    state_dbg
);
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       cap_row;
  logic [1:0]       cap_col;
  logic [1:0]       prio_row;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  logic             tick;
  logic             cap_pressed;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_s    <= 4'b1111;
    end else begin
      row_meta <= kp.row_in;
      row_s    <= row_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Lowest-numbered low row wins when several rows are pressed at once.
  always_comb begin
    prio_row = 2'd3;
    if (!row_s[0])      prio_row = 2'd0;
    else if (!row_s[1]) prio_row = 2'd1;
    else if (!row_s[2]) prio_row = 2'd2;
  end

  assign cap_pressed = ~row_s[cap_row];
  assign kp.col_out  = ~(4'b0001 << col_idx);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      col_idx      <= 2'd0;
      cap_row      <= 2'd0;
      cap_col      <= 2'd0;
      deb_cnt      <= '0;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt      <= '0;
`endif
    end else begin
      kp.key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (row_s == 4'b1111) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              cap_row <= prio_row;
              cap_col <= col_idx;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (!cap_pressed) begin
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end else if (deb_cnt == DEB_LAST) begin
              kp.key_code  <= {cap_row, cap_col};
              kp.key_valid <= 1'b1;
              kp.key_down  <= 1'b1;
              deb_cnt      <= '0;
              state        <= HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt      <= '0;
`endif
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // The column stays parked on cap_col, so only the captured row matters here.
          if (tick) begin
            if (cap_pressed) begin
              deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_cnt == REP_LAST) begin
                kp.key_valid <= 1'b1;
                rep_cnt      <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
              if (deb_cnt == DEB_LAST) begin
                kp.key_down <= 1'b0;
                deb_cnt     <= '0;
                col_idx     <= col_idx + 2'd1;
                state       <= SCAN;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state       <= SCAN;
          col_idx     <= 2'd0;
          deb_cnt     <= '0;
          kp.key_down <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: keypad matrix model, vector tables, corner sequences.
module tb_keypad_scan;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] exp_col;
    logic       exp_down;
  } scan_vec_t;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
    logic [3:0] exp_col_after;
  } key_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] keys = '0;
  logic [1:0]  state_dbg;
  int          total = 0;
  int          bad = 0;
  int          pulse_cnt = 0;
  int          pushed = 0;
  logic [3:0]  exp_q[$];

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kp.master),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected finish");
    $fatal(1, "watchdog expired");
  end

  // A pressed key shorts its row to its column whenever that column is driven low.
  always_comb begin
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
    kp.row_in = rows;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(code);
      pushed++;
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected key code.
  always @(negedge clk) begin
    if (rst_n && kp.key_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got key_code=%0d expected no pulse", kp.key_code);
      end else begin
        check("pulse_key_code", kp.key_code, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick_step();
    repeat (SCAN_DIV) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_step();
  endtask

  task automatic assert_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_col_out"}, kp.col_out, 4'b1110);
    check({name, "_key_code"}, kp.key_code, 4'd0);
    check({name, "_key_valid"}, kp.key_valid, 1'b0);
    check({name, "_key_down"}, kp.key_down, 1'b0);
    check({name, "_state"}, state_dbg, 2'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    scan_vec_t scan_tbl[5];
    key_vec_t  key_tbl[6];
    int        cur_col;
    int        lat;
    int        rel;
    int        exp_lat;
    int        n_rep;
    int        rep_a;
    int        rep_b;

    scan_tbl[0] = '{4'b1110, 1'b0};
    scan_tbl[1] = '{4'b1101, 1'b0};
    scan_tbl[2] = '{4'b1011, 1'b0};
    scan_tbl[3] = '{4'b0111, 1'b0};
    scan_tbl[4] = '{4'b1110, 1'b0};

    key_tbl[0] = '{0, 0, 4'd0,  4'b1101};
    key_tbl[1] = '{1, 3, 4'd7,  4'b1110};
    key_tbl[2] = '{2, 2, 4'd10, 4'b0111};
    key_tbl[3] = '{3, 3, 4'd15, 4'b1110};
    key_tbl[4] = '{3, 1, 4'd13, 4'b1011};
    key_tbl[5] = '{0, 2, 4'd2,  4'b0111};

    #2;
    assert_reset("rst");
    release_reset();

    // Idle scanning: one column step per tick, no key activity.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick_step();
      check($sformatf("scan_col_%0d", i), kp.col_out, scan_tbl[i].exp_col);
      check($sformatf("scan_down_%0d", i), kp.key_down, scan_tbl[i].exp_down);
    end

    // Key 9 (row 2, col 1) held 20 ticks from col 0.
    keys[9] = 1'b1;
    push_exp(4'd9, REP_ON ? 4 : 1);
    ticks(4);
    check("k9_down_before", kp.key_down, 1'b0);
    tick_step();
    check("k9_valid", kp.key_valid, 1'b1);
    check("k9_code", kp.key_code, 4'd9);
    check("k9_down", kp.key_down, 1'b1);
    check("k9_state_hold", state_dbg, 2'd2);
    ticks(15);
    check("k9_down_held", kp.key_down, 1'b1);
    check("k9_col_held", kp.col_out, 4'b1101);
    keys = '0;
    ticks(2);
    check("k9_down_rel2", kp.key_down, 1'b1);
    tick_step();
    check("k9_down_rel3", kp.key_down, 1'b0);
    check("k9_col_resume", kp.col_out, 4'b1011);

    // One-tick glitch on row 0 at column 3.
    tick_step();
    check("gl_col3", kp.col_out, 4'b0111);
    keys[3] = 1'b1;
    tick_step();
    check("gl_state_deb", state_dbg, 2'd1);
    keys = '0;
    tick_step();
    check("gl_col_after", kp.col_out, 4'b1110);
    check("gl_state_scan", state_dbg, 2'd0);
    check("gl_down", kp.key_down, 1'b0);

    // Rows 1 and 3 together at column 0, then a second key during HOLD.
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    push_exp(4'd4, 1);
    ticks(3);
    check("pr_down_before", kp.key_down, 1'b0);
    tick_step();
    check("pr_code", kp.key_code, 4'd4);
    check("pr_down", kp.key_down, 1'b1);
    keys[0] = 1'b1;
    ticks(4);
    check("pr_down_held", kp.key_down, 1'b1);
    check("pr_code_held", kp.key_code, 4'd4);
    check("pr_col_held", kp.col_out, 4'b1110);
    keys = '0;
    ticks(3);
    check("pr_down_rel", kp.key_down, 1'b0);
    check("pr_col_after", kp.col_out, 4'b1101);
    check("pr_code_kept", kp.key_code, 4'd4);

    // Release bounce on key 5: high, low, high, high, high.
    keys[5] = 1'b1;
    push_exp(4'd5, 1);
    ticks(4);
    check("rb_code", kp.key_code, 4'd5);
    check("rb_down", kp.key_down, 1'b1);
    ticks(2);
    keys = '0;
    tick_step();
    keys[5] = 1'b1;
    tick_step();
    keys = '0;
    ticks(2);
    check("rb_down_still", kp.key_down, 1'b1);
    tick_step();
    check("rb_down_rel", kp.key_down, 1'b0);
    check("rb_col_after", kp.col_out, 4'b1011);

    // Vector table: latency from the current column, code, release count, resume column.
    cur_col = 2;
    for (int i = 0; i < 6; i++) begin
      keys = '0;
      keys[key_tbl[i].row*4 + key_tbl[i].col] = 1'b1;
      push_exp(key_tbl[i].exp_code, 1);
      exp_lat = ((key_tbl[i].col - cur_col + 4) % 4) + 1 + DEBOUNCE_CNT;
      lat = 0;
      while (!kp.key_down && lat < 12) begin
        tick_step();
        lat++;
      end
      check($sformatf("tbl%0d_latency", i), lat, exp_lat);
      check($sformatf("tbl%0d_code", i), kp.key_code, key_tbl[i].exp_code);
      tick_step();
      keys = '0;
      rel = 0;
      while (kp.key_down && rel < 8) begin
        tick_step();
        rel++;
      end
      check($sformatf("tbl%0d_release", i), rel, DEBOUNCE_CNT);
      check($sformatf("tbl%0d_col_after", i), kp.col_out, key_tbl[i].exp_col_after);
      cur_col = (key_tbl[i].col + 1) % 4;
    end

    // 12-tick hold on key 7: repeat pulses only when auto-repeat is built in.
    keys[7] = 1'b1;
    push_exp(4'd7, REP_ON ? 3 : 1);
    lat = 0;
    while (!kp.key_valid && lat < 12) begin
      tick_step();
      lat++;
    end
    check("ar_latency", lat, 1 + DEBOUNCE_CNT);
    n_rep = 0;
    rep_a = 0;
    rep_b = 0;
    for (int t = 1; t <= 12; t++) begin
      tick_step();
      if (kp.key_valid) begin
        n_rep++;
        if (n_rep == 1) rep_a = t;
        if (n_rep == 2) rep_b = t;
      end
    end
    check("ar_repeats", n_rep, REP_ON ? 2 : 0);
    check("ar_first_at", rep_a, REP_ON ? 5 : 0);
    check("ar_second_at", rep_b, REP_ON ? 10 : 0);
    keys = '0;
    ticks(3);
    check("ar_down_rel", kp.key_down, 1'b0);

    // Reset asserted while debouncing key 8 at column 0.
    check("md_col0", kp.col_out, 4'b1110);
    keys[8] = 1'b1;
    tick_step();
    check("md_state_deb", state_dbg, 2'd1);
    tick_step();
    #3;
    assert_reset("mid_rst");
    keys = '0;
    release_reset();
    ticks(8);
    check("md_col_after", kp.col_out, 4'b1110);
    check("md_down_after", kp.key_down, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("pulse_total", pulse_cnt, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
